wb_writeback_unit: RTL and testbench

Receiving end of the write-back control bundle: captures the 3-bit WB control word, three candidate result words and the destination register at the MEM/WB boundary, selects the write-back data and commits it to the 32×32 general-purpose register file. It also serves the decode stage's two read ports, with same-cycle write-to-read bypass, and exports the committed write for the forwarding unit. It sits between the MEM stage outputs and the ID-stage register reads of the pipelined MIPS core.

---
 rtl/wb_writeback_unit_pkg.sv | 31 +++
 rtl/wb_writeback_unit_if.sv | 34 +++
 rtl/wb_writeback_unit_regfile.sv | 35 +++
 rtl/wb_writeback_unit.sv | 83 ++++++++
 tb/tb_wb_writeback_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_writeback_unit_pkg.sv
// Write-back control field positions, MemtoReg encodings and register-file geometry
// shared by the MEM/WB capture logic and the register file.
package wb_writeback_unit_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 1 << REG_ADDR_W;
  localparam int SP_INDEX     = 29;
  localparam int REGWRITE_BIT = 2;
  localparam int MEMTOREG_MSB = 1;
  localparam int MEMTOREG_LSB = 0;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10,
    MTR_RSV = 2'b11
  } mtr_e;

  typedef struct packed {
    logic reg_write;
    mtr_e mem_to_reg;
  } wb_ctrl_t;

  function automatic wb_ctrl_t unpack_ctrl(input logic [2:0] ctrl);
    wb_ctrl_t c;
    c.reg_write  = ctrl[REGWRITE_BIT];
    c.mem_to_reg = mtr_e'(ctrl[MEMTOREG_MSB:MEMTOREG_LSB]);
    return c;
  endfunction

endpackage

// File: rtl/wb_writeback_unit_if.sv
// MEM/WB input bundle, decode-stage read ports and committed-write export.
// master = pipeline side driving the stage, slave = write-back unit.
interface wb_writeback_unit_if #(
  parameter int DATA_W = 32
) ();

  logic              enable;
  logic              flush;
  logic [2:0]        wb_ctrl_i;
  logic [DATA_W-1:0] alu_result_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] pc_plus4_i;
  logic [4:0]        write_reg_i;
  logic [4:0]        rs_addr_i;
  logic [4:0]        rt_addr_i;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic              wb_reg_write_o;
  logic [4:0]        wb_write_reg_o;
  logic [DATA_W-1:0] wb_data_o;

  modport master (
    output enable, flush, wb_ctrl_i, alu_result_i, mem_data_i, pc_plus4_i,
           write_reg_i, rs_addr_i, rt_addr_i,
    input  rs_data_o, rt_data_o, wb_reg_write_o, wb_write_reg_o, wb_data_o
  );

  modport slave (
    input  enable, flush, wb_ctrl_i, alu_result_i, mem_data_i, pc_plus4_i,
           write_reg_i, rs_addr_i, rt_addr_i,
    output rs_data_o, rt_data_o, wb_reg_write_o, wb_write_reg_o, wb_data_o
  );

endinterface

// File: rtl/wb_writeback_unit_regfile.sv
// 32-entry GPR file: one write port, two combinational read ports, $0 hardwired to zero.
// Write lands on the rising edge; r29 resets to the stack-pointer seed, all others to 0.
module gp_register_file
  import wb_writeback_unit_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_0FFC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/wb_writeback_unit.sv
// MEM/WB pipeline register, write-back data select and GPR commit with write-to-read bypass.
// wb_* valid one edge after capture, array updated the edge after; enable=0 holds, flush inserts a bubble.
module wb_writeback_unit
  import wb_writeback_unit_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_0FFC
) (
  input  logic               clk,
  input  logic               reset,
  wb_writeback_unit_if.slave bus
);

  wb_ctrl_t              ctrl_q;
  logic [DATA_W-1:0]     alu_q;
  logic [DATA_W-1:0]     mem_q;
  logic [DATA_W-1:0]     pc4_q;
  logic [REG_ADDR_W-1:0] dest_q;

  logic [DATA_W-1:0]     wb_data;
  logic                  wb_we;
  logic [DATA_W-1:0]     rf_rs;
  logic [DATA_W-1:0]     rf_rt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      mem_q  <= '0;
      pc4_q  <= '0;
      dest_q <= '0;
    end else if (bus.flush) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      mem_q  <= '0;
      pc4_q  <= '0;
      dest_q <= '0;
    end else if (bus.enable) begin
      ctrl_q <= unpack_ctrl(bus.wb_ctrl_i);
      alu_q  <= bus.alu_result_i;
      mem_q  <= bus.mem_data_i;
      pc4_q  <= bus.pc_plus4_i;
      dest_q <= bus.write_reg_i;
    end
  end

  always_comb begin
    wb_data = '0;
    case (ctrl_q.mem_to_reg)
      MTR_ALU: wb_data = alu_q;
      MTR_MEM: wb_data = mem_q;
      MTR_PC4: wb_data = pc4_q;
      default: wb_data = '0;
    endcase
  end

  // Reserved select and $0 destination both suppress the commit, which also keeps $0 at zero.
  assign wb_we = ctrl_q.reg_write && (ctrl_q.mem_to_reg != MTR_RSV) && (dest_q != '0);

  gp_register_file #(
    .DATA_W   (DATA_W),
    .SP_RESET (SP_RESET)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (dest_q),
    .wdata   (wb_data),
    .raddr_a (bus.rs_addr_i),
    .rdata_a (rf_rs),
    .raddr_b (bus.rt_addr_i),
    .rdata_b (rf_rt)
  );

  // wb_we is never set for $0, so the bypass cannot leak a value onto a $0 read.
  assign bus.rs_data_o = (wb_we && (bus.rs_addr_i == dest_q)) ? wb_data : rf_rs;
  assign bus.rt_data_o = (wb_we && (bus.rt_addr_i == dest_q)) ? wb_data : rf_rt;

  assign bus.wb_reg_write_o = wb_we;
  assign bus.wb_write_reg_o = dest_q;
  assign bus.wb_data_o      = wb_data;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed plus randomized stimulus against an array-based register model; a negedge monitor
// pops per-cycle expectations from a scoreboard queue and compares all outputs.
module tb_wb_writeback_unit;

  localparam logic [31:0] SP_SEED = 32'h0000_0FFC;

  logic clk;
  logic reset;

  wb_writeback_unit_if #(.DATA_W(32)) bus ();

  wb_writeback_unit #(
    .DATA_W   (32),
    .SP_RESET (SP_SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: architectural registers plus the instruction sitting in WB.
  logic [31:0] m_regs [32];
  logic        m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_data;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? SP_SEED : 32'h0;
    m_we   = 1'b0;
    m_dest = 5'd0;
    m_data = 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (m_we && (a == m_dest)) return m_data;
    return m_regs[a];
  endfunction

  // Drive one cycle of inputs, record what the DUT must show during it, then advance the model.
  task automatic cycle(input logic en, input logic fl, input logic [2:0] ctrl,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rst_n);
    exp_t e;
    bus.enable       = en;
    bus.flush        = fl;
    bus.wb_ctrl_i    = ctrl;
    bus.alu_result_i = alu;
    bus.mem_data_i   = mem;
    bus.pc_plus4_i   = pc;
    bus.write_reg_i  = wr;
    bus.rs_addr_i    = rs;
    bus.rt_addr_i    = rt;
    reset            = rst_n;
    if (!rst_n) model_reset();
    e.we   = m_we;
    e.dest = m_dest;
    e.data = m_data;
    e.rs_a = rs;
    e.rt_a = rt;
    e.rs   = model_read(rs);
    e.rt   = model_read(rt);
    sb.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (m_we) m_regs[m_dest] = m_data;
      if (fl) begin
        m_we = 1'b0; m_dest = 5'd0; m_data = 32'h0;
      end else if (en) begin
        m_dest = wr;
        case (ctrl[1:0])
          2'b00:   m_data = alu;
          2'b01:   m_data = mem;
          2'b10:   m_data = pc;
          default: m_data = 32'h0;
        endcase
        m_we = ctrl[2] && (ctrl[1:0] != 2'b11) && (wr != 5'd0);
      end
    end
    #1;
  endtask

  task automatic nop(input logic [4:0] rs, input logic [4:0] rt);
    cycle(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, rs, rt, 1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wb_reg_write", {31'h0, bus.wb_reg_write_o}, {31'h0, e.we});
        check("wb_write_reg", {27'h0, bus.wb_write_reg_o}, {27'h0, e.dest});
        check("wb_data", bus.wb_data_o, e.data);
        check($sformatf("rs_data[r%0d]", e.rs_a), bus.rs_data_o, e.rs);
        check($sformatf("rt_data[r%0d]", e.rt_a), bus.rt_data_o, e.rt);
      end
    end
  end

  initial begin : stimulus
    logic [4:0] rs, rt;
    reset = 1'b0;
    bus.enable = 1'b0; bus.flush = 1'b0; bus.wb_ctrl_i = 3'b0;
    bus.alu_result_i = '0; bus.mem_data_i = '0; bus.pc_plus4_i = '0;
    bus.write_reg_i = '0; bus.rs_addr_i = '0; bus.rt_addr_i = '0;
    model_reset();
    #2;
    @(posedge clk);
    #1;

    // Reset state: r29 seeded, r5 zero.
    cycle(1'b1, 1'b0, 3'b100, 32'h1, 32'h0, 32'h0, 5'd5, 5'd29, 5'd5, 1'b0);
    cycle(1'b1, 1'b0, 3'b100, 32'h1, 32'h0, 32'h0, 5'd5, 5'd29, 5'd5, 1'b0);

    // ALU write to r8: bypass, then array.
    cycle(1'b1, 1'b0, 3'b100, 32'h1234_5678, 32'h0, 32'h0, 5'd8, 5'd29, 5'd5, 1'b1);
    nop(5'd8, 5'd8);
    nop(5'd8, 5'd0);

    // Load to r9, jal link to r31.
    cycle(1'b1, 1'b0, 3'b101, 32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 5'd9, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 3'b110, 32'h3333_3333, 32'h4444_4444, 32'h0040_0024, 5'd31, 5'd9, 5'd0, 1'b1);
    nop(5'd9, 5'd31);
    nop(5'd9, 5'd31);

    // $0 write and reserved select.
    cycle(1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, 3'b111, 32'h7777_7777, 32'h8888_8888, 32'h9999_9999, 5'd4, 5'd0, 5'd4, 1'b1);
    nop(5'd4, 5'd0);

    // Stall three cycles with garbage on the inputs.
    cycle(1'b1, 1'b0, 3'b100, 32'h0000_0055, 32'h0, 32'h0, 5'd7, 5'd7, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 5'd7, 5'd7, 1'b1);

    // Flush wins over enable.
    cycle(1'b1, 1'b1, 3'b100, 32'h0000_0099, 32'h0, 32'h0, 5'd10, 5'd7, 5'd10, 1'b1);
    nop(5'd10, 5'd7);

    // Dual-port bypass on r12.
    cycle(1'b1, 1'b0, 3'b100, 32'h0000_00AA, 32'h0, 32'h0, 5'd12, 5'd0, 5'd0, 1'b1);
    nop(5'd12, 5'd12);

    // Reset while a write to r3 is pending in WB and the stage is stalled.
    cycle(1'b1, 1'b0, 3'b100, 32'h0000_0003, 32'h0, 32'h0, 5'd3, 5'd3, 5'd29, 1'b1);
    cycle(1'b0, 1'b0, 3'b100, 32'h0000_0004, 32'h0, 32'h0, 5'd3, 5'd3, 5'd29, 1'b0);
    nop(5'd3, 5'd12);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      rs = ($urandom_range(0, 2) == 0) ? m_dest : 5'($urandom);
      rt = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 3'($urandom),
            $urandom, $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15)),
            rs, rt, $urandom_range(0, 59) != 0);
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
